muldiv_unit: RTL

- Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the ALU operand-select stage.
- Consumes the same selected operands as the ALU (src1 = alu_in1, src2 = alu_in2) when the decoded op is a mul/div op.
- Multi-cycle, with valid/ready handshakes on both sides. The pipeline stalls on in_ready/out_valid.

---
 rtl/muldiv_unit_pkg.sv | 14 +
 rtl/muldiv_unit_if.sv | 12 +
 rtl/muldiv_divider.sv | 52 +++++
 rtl/muldiv_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encoding, FSM states, iteration counts and small helpers
// shared by the RV64M multiply/divide unit.
package muldiv_unit_pkg;
    typedef enum logic [2:0] {MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU} muldiv_op_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_t;
    localparam int MD_ITER_D = 64;
    localparam int MD_ITER_W = 32;
    function automatic logic [5:0] last_iter(input logic is_word);
        return is_word ? 6'(MD_ITER_W - 1) : 6'(MD_ITER_D - 1);
    endfunction
    function automatic logic [63:0] word_fix(input logic is_word, input logic [63:0] v);
        return is_word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response handshake bundle between the execute stage
// (master) and the multiply/divide unit (slave).
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;
    logic        in_valid, in_ready, is_word, out_valid, out_ready, busy;
    muldiv_op_t  op;
    logic [63:0] src1, src2, result;
    modport master (output in_valid, op, is_word, src1, src2, out_ready,
                    input in_ready, out_valid, result, busy);
    modport slave (input in_valid, op, is_word, src1, src2, out_ready,
                   output in_ready, out_valid, result, busy);
endinterface

// File: rtl/muldiv_divider.sv
// muldiv_divider: unsigned restoring divider, one quotient bit per cycle.
// done is high during the last iteration; quotient/remainder then show the final values.
module muldiv_divider
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        start,
    input  logic        is_word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        done,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);
    logic        run_q, word_q, ge;
    logic [5:0]  cnt_q;
    logic [63:0] quo_q, rem_q, dvs_q, shifted;
    // rem_q[63] set means the shifted partial remainder exceeds any 64-bit divisor
    always_comb begin
        shifted   = {rem_q[62:0], quo_q[63]};
        ge        = rem_q[63] || shifted >= dvs_q;
        quotient  = {quo_q[62:0], ge};
        remainder = ge ? shifted - dvs_q : shifted;
        done      = run_q && cnt_q == last_iter(word_q);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q  <= 1'b0;
            word_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            run_q  <= 1'b1;
            word_q <= is_word;
            cnt_q  <= '0;
            quo_q  <= is_word ? {dividend[31:0], 32'b0} : dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (flush || done) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (run_q) begin
            cnt_q <= cnt_q + 6'd1;
            quo_q <= quotient;
            rem_q <= remainder;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide with valid/ready handshakes and flush.
// Defining MULDIV_FAST_MUL_EN replaces shift-add multiply with a single-cycle product.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    muldiv_unit_if.slave md
);
    md_state_t   state_q, state_d, start_state;
    muldiv_op_t  op_q;
    logic        word_q, qneg_q, rneg_q, ext_signed, div_signed, accept;
    logic        div_zero, div_ovf, mul_last, div_start, div_done;
    logic [5:0]  cnt_q;
    logic [63:0] x1, x2, a_abs, b_abs, a_q, b_q, prod_q, result_q;
    logic [63:0] fast_prod, start_res, mul_nxt, quo, rem, div_raw;
`ifdef MULDIV_FAST_MUL_EN
    localparam md_state_t MUL_STATE = S_DONE;
`else
    localparam md_state_t MUL_STATE = S_MUL;
`endif
    always_comb begin
        ext_signed  = md.op inside {MD_MUL, MD_DIV, MD_REM};
        div_signed  = md.op inside {MD_DIV, MD_REM};
        x1          = md.is_word ? {{32{ext_signed & md.src1[31]}}, md.src1[31:0]} : md.src1;
        x2          = md.is_word ? {{32{ext_signed & md.src2[31]}}, md.src2[31:0]} : md.src2;
        a_abs       = div_signed && x1[63] ? -x1 : x1;
        b_abs       = div_signed && x2[63] ? -x2 : x2;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod   = x1 * x2;
`else
        fast_prod   = '0;
`endif
        accept      = state_q == S_IDLE && md.in_valid && !flush;
        div_zero    = md.op != MD_MUL && x2 == '0;
        div_ovf     = div_signed && x2 == '1 &&
                      x1 == (md.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000);
        start_state = md.op == MD_MUL ? MUL_STATE : (div_zero || div_ovf) ? S_DONE : S_DIV;
        // Result known at accept: fast product or a divide special case
        start_res   = word_fix(md.is_word, md.op == MD_MUL ? fast_prod :
                      md.op inside {MD_DIV, MD_DIVU} ? (div_zero ? '1 : x1) : (div_zero ? x1 : '0));
        div_start   = accept && start_state == S_DIV;
        mul_nxt     = prod_q + (b_q[0] ? a_q : '0);
        mul_last    = state_q == S_MUL && cnt_q == last_iter(word_q);
        div_raw     = op_q inside {MD_REM, MD_REMU} ? (rneg_q ? -rem : rem) : (qneg_q ? -quo : quo);
        state_d     = flush ? S_IDLE :
                      state_q == S_IDLE ? (accept ? start_state : S_IDLE) :
                      state_q == S_MUL  ? (mul_last ? S_DONE : S_MUL) :
                      state_q == S_DIV  ? (div_done ? S_DONE : S_DIV) :
                      (md.out_ready ? S_IDLE : S_DONE);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= MD_MUL;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= md.op;
                word_q   <= md.is_word;
                qneg_q   <= div_signed & (x1[63] ^ x2[63]);
                rneg_q   <= div_signed & x1[63];
                cnt_q    <= '0;
                a_q      <= x1;
                b_q      <= x2;
                prod_q   <= '0;
                result_q <= start_res;
            end else if (state_q == S_MUL) begin
                cnt_q  <= cnt_q + 6'd1;
                a_q    <= a_q << 1;
                b_q    <= b_q >> 1;
                prod_q <= mul_nxt;
                if (mul_last) result_q <= word_fix(word_q, mul_nxt);
            end else if (div_done) begin
                result_q <= word_fix(word_q, div_raw);
            end
        end
    end
    muldiv_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (div_start),
        .is_word   (md.is_word),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );
    assign md.in_ready  = state_q == S_IDLE;
    assign md.out_valid = state_q == S_DONE;
    assign md.busy      = state_q != S_IDLE;
    assign md.result    = result_q;
endmodule
